cmd_sequencer: RTL and testbench

//  Upstream stage of the opcode-driven testbench harness: stores a program of access commands
//  (nop / write reg / read reg / write mem / read mem) and replays it onto the harness opcode,
//  id, mask, in and addr inputs, one command per HOLD cycles.

---
 rtl/cmd_seq_pkg.sv | 35 +++
 rtl/cmd_seq_mem.sv | 25 ++
 rtl/cmd_sequencer.sv | 156 +++++++++++++++
 tb/tb_cmd_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types for the command sequencer: command record, opcodes, FSM states.
// Optional build macro: CMD_SEQ_STOP_ON_ERR_EN (see cmd_sequencer).
package cmd_seq_pkg;

    localparam int CMD_W = 193;

    typedef enum logic [31:0] {
        OP_NOP    = 32'd0,
        OP_WR_REG = 32'd1,
        OP_RD_REG = 32'd2,
        OP_WR_MEM = 32'd3,
        OP_RD_MEM = 32'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] id;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] expd;
        logic        check;
    } cmd_t;

    function automatic logic is_read(input logic [31:0] op);
        return (op == OP_RD_REG) || (op == OP_RD_MEM);
    endfunction

endpackage

// File: rtl/cmd_seq_mem.sv
// Program store: DEPTH x W registers, one synchronous write port,
// one asynchronous read port.
module cmd_seq_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 193
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_sequencer.sv
// Replays a loaded command program onto the harness ports and counts read mismatches.
// Build macro CMD_SEQ_STOP_ON_ERR_EN ends the run on the first mismatch.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int HOLD  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [CMD_W-1:0]           ld_cmd,
    input  logic                       start,
    input  logic                       clear,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [15:0]                err_count,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count,
    output logic [31:0]                tb_opcode,
    output logic [31:0]                tb_id,
    output logic [31:0]                tb_mask,
    output logic [31:0]                tb_in,
    output logic [31:0]                tb_addr,
    input  logic [31:0]                tb_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int HW = $clog2(HOLD+1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD-1);

`ifdef CMD_SEQ_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    logic [HW-1:0]   hold_q;
    logic [15:0]     err_q;
    cmd_t            cur_q;

    logic            ld_fire;
    logic [CW-1:0]   cnt_d;
    logic            step;
    logic            last;
    logic            mism;
    logic [AW-1:0]   rd_addr;
    logic [CMD_W-1:0] rd_raw;
    cmd_t            nxt_cmd;

    assign ld_ready = (state_q == IDLE) && (cnt_q < CW'(DEPTH));
    assign ld_fire  = ld_valid && ld_ready;
    assign cnt_d    = cnt_q + CW'(ld_fire);

    assign step = (state_q == RUN) && (hold_q == HOLD_LAST);
    assign last = (CW'(idx_q) == cnt_q - CW'(1));
    assign mism = cur_q.check && is_read(cur_q.opcode)
               && (tb_out != cur_q.expd);

    // Read address is the entry to be shown next cycle; a same-edge
    // load into slot 0 is forwarded so start+load replays it at once.
    assign rd_addr = (state_q == RUN) ? idx_q + AW'(1) : '0;
    assign nxt_cmd = (ld_fire && cnt_q == '0) ? cmd_t'(ld_cmd)
                                              : cmd_t'(rd_raw);

    cmd_seq_mem #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (ld_fire),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (ld_cmd),
        .raddr_i (rd_addr),
        .rdata_o (rd_raw)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            cur_q   <= '0;
        end else begin
            if (ld_fire) begin
                cnt_q <= cnt_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q  <= '0;
                        hold_q <= '0;
                        err_q  <= '0;
                        if (cnt_d != '0) begin
                            state_q <= RUN;
                            cur_q   <= nxt_cmd;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (step) begin
                        if (mism && err_q != 16'hFFFF) begin
                            err_q <= err_q + 16'd1;
                        end
                        if (last || (STOP_ON_ERR && mism)) begin
                            state_q <= DONE;
                            cur_q   <= '0;
                        end else begin
                            idx_q  <= idx_q + AW'(1);
                            hold_q <= '0;
                            cur_q  <= nxt_cmd;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                DONE: begin
                    if (clear) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (start) begin
                        idx_q  <= '0;
                        hold_q <= '0;
                        err_q  <= '0;
                        if (cnt_q != '0) begin
                            state_q <= RUN;
                            cur_q   <= nxt_cmd;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign fail      = (err_q != 16'd0);
    assign err_count = err_q;
    assign cmd_count = cnt_q;
    assign tb_opcode = cur_q.opcode;
    assign tb_id     = cur_q.id;
    assign tb_mask   = cur_q.mask;
    assign tb_in     = cur_q.data;
    assign tb_addr   = cur_q.addr;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: vector table, hand sequences,
// and randomized programs against a reference model of the harness.
module tb_cmd_sequencer;
    import cmd_seq_pkg::*;

`ifdef CMD_SEQ_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // HOLD=1 instance
    logic rst, lv, st, cl, rdy, bsy, dn, fl;
    logic [CMD_W-1:0] lcmd;
    logic [15:0] err;
    logic [4:0] cnt;
    logic [31:0] op, id, msk, din, adr, dout;

    cmd_sequencer #(.DEPTH(16), .HOLD(1)) dut (
        .clock(clock), .reset(rst), .ld_valid(lv), .ld_ready(rdy),
        .ld_cmd(lcmd), .start(st), .clear(cl), .busy(bsy), .done(dn),
        .fail(fl), .err_count(err), .cmd_count(cnt), .tb_opcode(op),
        .tb_id(id), .tb_mask(msk), .tb_in(din), .tb_addr(adr),
        .tb_out(dout)
    );

    // HOLD=3 instance
    logic rst3, lv3, st3, cl3, rdy3, bsy3, dn3, fl3;
    logic [CMD_W-1:0] lcmd3;
    logic [15:0] err3;
    logic [4:0] cnt3;
    logic [31:0] op3, id3, msk3, din3, adr3, dout3;

    cmd_sequencer #(.DEPTH(16), .HOLD(3)) dut3 (
        .clock(clock), .reset(rst3), .ld_valid(lv3), .ld_ready(rdy3),
        .ld_cmd(lcmd3), .start(st3), .clear(cl3), .busy(bsy3), .done(dn3),
        .fail(fl3), .err_count(err3), .cmd_count(cnt3), .tb_opcode(op3),
        .tb_id(id3), .tb_mask(msk3), .tb_in(din3), .tb_addr(adr3),
        .tb_out(dout3)
    );

    // Simple harness model: register file by id, memory by addr
    logic hclr;
    logic [31:0] hmem [16];
    logic [31:0] hreg [16];

    always @(posedge clock) begin
        if (hclr) begin
            for (int i = 0; i < 16; i++) begin
                hmem[i] <= 32'd0;
                hreg[i] <= 32'd0;
            end
        end else if (op == 32'd3) begin
            hmem[adr[3:0]] <= din;
        end else if (op == 32'd1) begin
            hreg[id[3:0]] <= din;
        end
    end

    assign dout = (op == 32'd4) ? hmem[adr[3:0]] :
                  (op == 32'd2) ? hreg[id[3:0]] : 32'd0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input cmd_t c);
        lv = 1'b1;
        lcmd = c;
        cyc();
        lv = 1'b0;
    endtask

    typedef struct {
        bit r, l, s, c;
        int cs;
        bit e_rdy, e_bsy, e_dn, e_fl;
        int e_err, e_cnt, e_op;
    } vec_t;

    function automatic vec_t mk(bit r, bit l, int cs, bit s, bit c,
                                bit rd, bit b, bit d, bit f,
                                int e, int n, int o);
        vec_t v;
        v.r = r; v.l = l; v.cs = cs; v.s = s; v.c = c;
        v.e_rdy = rd; v.e_bsy = b; v.e_dn = d; v.e_fl = f;
        v.e_err = e; v.e_cnt = n; v.e_op = o;
        return v;
    endfunction

    function automatic cmd_t mkc(int o, int i, int a, int d, int e, bit k);
        cmd_t c;
        c.opcode = 32'(o); c.id = 32'(i); c.mask = 32'hFFFF_FFFF;
        c.data = 32'(d); c.addr = 32'(a); c.expd = 32'(e); c.check = k;
        return c;
    endfunction

    cmd_t cmds [4];
    vec_t tbl [$];
    cmd_t prog [16];
    logic [31:0] mm [4];
    logic [31:0] rr [4];

    initial begin
        cmds[0] = mkc(3, 0, 2, 32'hA5A5A5A5, 0, 1'b0);
        cmds[1] = mkc(4, 0, 2, 0, 32'hA5A5A5A5, 1'b1);
        cmds[2] = mkc(0, 0, 0, 0, 0, 1'b0);
        cmds[3] = mkc(4, 0, 2, 0, 32'h12345678, 1'b1);

        //           r l cs s c  rdy b d f err cnt op
        tbl.push_back(mk(1,0,0,0,0, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,1,0,0, 1,0,0,0, 0,2,0));
        tbl.push_back(mk(0,1,2,0,0, 1,0,0,0, 0,3,0));
        tbl.push_back(mk(0,0,0,1,0, 0,1,0,0, 0,3,3));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,3,4));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,3,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,3,0));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,3,0,0, 1,0,0,0, 0,2,0));
        tbl.push_back(mk(0,1,2,0,0, 1,0,0,0, 0,3,0));
        tbl.push_back(mk(0,0,0,1,0, 0,1,0,0, 0,3,3));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,3,4));
        tbl.push_back(STOP ? mk(0,0,0,0,0, 0,0,1,1, 1,3,0)
                           : mk(0,0,0,0,0, 0,1,0,1, 1,3,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,1, 1,3,0));
        tbl.push_back(mk(0,0,0,1,0, 0,1,0,0, 0,3,3));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,0, 0,3,4));
        tbl.push_back(STOP ? mk(0,0,0,0,0, 0,0,1,1, 1,3,0)
                           : mk(0,0,0,0,0, 0,1,0,1, 1,3,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,1, 1,3,0));
        tbl.push_back(mk(0,0,0,1,1, 1,0,0,1, 1,0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,0, 0,1,0,0, 0,1,3));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,2,0,0, 1,0,0,0, 0,2,0));
        tbl.push_back(mk(0,0,0,1,0, 0,1,0,0, 0,2,3));
        tbl.push_back(mk(0,1,1,1,1, 0,1,0,0, 0,2,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,2,0));

        rst = 1'b1; lv = 1'b0; st = 1'b0; cl = 1'b0; lcmd = '0;
        rst3 = 1'b1; lv3 = 1'b0; st3 = 1'b0; cl3 = 1'b0; lcmd3 = '0;
        dout3 = 32'd0;
        hclr = 1'b1;
        cyc();
        hclr = 1'b0;
        rst3 = 1'b0;

        // Vector table
        foreach (tbl[k]) begin
            rst = tbl[k].r; lv = tbl[k].l; st = tbl[k].s; cl = tbl[k].c;
            lcmd = cmds[tbl[k].cs];
            cyc();
            chk($sformatf("v%0d_rdy", k), 32'(rdy), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d_busy", k), 32'(bsy), 32'(tbl[k].e_bsy));
            chk($sformatf("v%0d_done", k), 32'(dn), 32'(tbl[k].e_dn));
            chk($sformatf("v%0d_fail", k), 32'(fl), 32'(tbl[k].e_fl));
            chk($sformatf("v%0d_err", k), 32'(err), 32'(tbl[k].e_err));
            chk($sformatf("v%0d_cnt", k), 32'(cnt), 32'(tbl[k].e_cnt));
            chk($sformatf("v%0d_op", k), op, 32'(tbl[k].e_op));
        end
        rst = 1'b0; lv = 1'b0; st = 1'b0; cl = 1'b0;

        // Fill to capacity, then one extra load is dropped
        cl = 1'b1;
        cyc();
        cl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("full_rdy_before", 32'(rdy), 32'd1);
            load(mkc(3, 0, i % 4, i, 0, 1'b0));
        end
        chk("full_rdy", 32'(rdy), 32'd0);
        chk("full_cnt", 32'(cnt), 32'd16);
        load(cmds[1]);
        chk("full_drop_cnt", 32'(cnt), 32'd16);
        begin
            int busy_n;
            int guard;
            busy_n = 0;
            guard = 0;
            st = 1'b1;
            cyc();
            st = 1'b0;
            while (!dn && guard < 40) begin
                if (bsy) busy_n++;
                guard++;
                cyc();
            end
            chk("full_done_in_time", 32'(dn), 32'd1);
            chk("full_busy_len", 32'(busy_n), 32'd16);
            chk("full_err", 32'(err), 32'd0);
        end

        // HOLD=3: each command held three cycles
        load3: begin
            lv3 = 1'b1; lcmd3 = mkc(1, 1, 0, 32'h11, 0, 1'b0); cyc();
            lcmd3 = mkc(3, 0, 5, 32'h22, 0, 1'b0); cyc();
            lv3 = 1'b0;
            chk("h3_cnt", 32'(cnt3), 32'd2);
            st3 = 1'b1;
            cyc();
            st3 = 1'b0;
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("h3_busy%0d", k), 32'(bsy3), 32'd1);
                chk($sformatf("h3_op%0d", k), op3, (k < 3) ? 32'd1 : 32'd3);
                cyc();
            end
            chk("h3_done", 32'(dn3), 32'd1);
            chk("h3_op_done", op3, 32'd0);
            st3 = 1'b1;
            cyc();
            st3 = 1'b0;
            cyc(); cyc(); cyc();
            chk("h3_c4_op", op3, 32'd3);
            rst3 = 1'b1;
            cyc();
            rst3 = 1'b0;
            chk("h3_rst_busy", 32'(bsy3), 32'd0);
            chk("h3_rst_done", 32'(dn3), 32'd0);
            chk("h3_rst_rdy", 32'(rdy3), 32'd1);
            chk("h3_rst_cnt", 32'(cnt3), 32'd0);
            chk("h3_rst_op", op3, 32'd0);
            chk("h3_rst_in", din3, 32'd0);
            chk("h3_rst_addr", adr3, 32'd0);
            chk("h3_rst_err", 32'(err3), 32'd0);
        end

        // Randomized programs against the reference model
        for (int r = 0; r < 25; r++) begin
            int n;
            int e_err;
            int e_len;
            bit stopped;
            logic [31:0] val;
            cmd_t c;
            n = $urandom_range(1, 16);
            rst = 1'b1; hclr = 1'b1;
            cyc();
            rst = 1'b0; hclr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mm[i] = 32'd0;
                rr[i] = 32'd0;
            end
            e_err = 0;
            e_len = n;
            stopped = 1'b0;
            for (int i = 0; i < n; i++) begin
                c.opcode = 32'($urandom_range(0, 4));
                c.id = 32'($urandom_range(0, 3));
                c.addr = 32'($urandom_range(0, 3));
                c.data = $urandom;
                c.mask = $urandom;
                c.check = 1'($urandom_range(0, 1));
                val = (c.opcode == 32'd4) ? mm[c.addr[1:0]] :
                      (c.opcode == 32'd2) ? rr[c.id[1:0]] : 32'd0;
                c.expd = ($urandom_range(0, 1) == 1) ? val : $urandom;
                if (!stopped && c.check && val != c.expd &&
                    (c.opcode == 32'd2 || c.opcode == 32'd4)) begin
                    e_err++;
                    if (STOP) begin
                        stopped = 1'b1;
                        e_len = i + 1;
                    end
                end
                if (c.opcode == 32'd3) mm[c.addr[1:0]] = c.data;
                if (c.opcode == 32'd1) rr[c.id[1:0]] = c.data;
                prog[i] = c;
                load(c);
            end
            chk("rnd_cnt", 32'(cnt), 32'(n));
            st = 1'b1;
            cyc();
            st = 1'b0;
            for (int i = 0; i < e_len; i++) begin
                chk("rnd_busy", 32'(bsy), 32'd1);
                chk("rnd_op", op, prog[i].opcode);
                chk("rnd_addr", adr, prog[i].addr);
                cyc();
            end
            chk("rnd_done", 32'(dn), 32'd1);
            chk("rnd_err", 32'(err), 32'(e_err));
            chk("rnd_fail", 32'(fl), 32'(e_err != 0));
            chk("rnd_op_idle", op, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
